// File: rtl/if_id_fifo_pkg.sv
// rtl/if_id_fifo_pkg.sv - shared constants and types for the IF/ID decoupling buffer
// Purpose: pipeline-wide control encodings (reset, chip enable, stall) and the
//          fetched-word record carried from IF to ID.
// Ports:   none (package).
package if_id_fifo_pkg;

  localparam logic        RST_ENABLE  = 1'b1;
  localparam logic        CHIP_ENABLE = 1'b1;
  localparam logic        STOP        = 1'b1;
  localparam logic        NO_STOP     = 1'b0;
  localparam int          INST_ADDR_W = 32;
  localparam int          INST_W      = 32;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam int          IFQ_DEPTH   = 4;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// rtl/if_id_fifo_mem.sv - storage array for buffered {pc, inst} pairs
// Purpose: DEPTH x W register array, one synchronous write port and an
//          asynchronous read of the entry addressed by rd_addr (the head).
//          Data is not reset; validity is tracked by the owner's count.
// Ports:   Clk      clock
//          wr_en    write strobe
//          wr_addr  write index (tail)
//          wr_data  word to store
//          rd_addr  read index (head)
//          rd_data  stored word at rd_addr
module if_id_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int W     = 64
) (
  input  logic             Clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - IF/ID decoupling buffer with registered output to ID
// Purpose: captures each word IF retires, buffers up to DEPTH of them while ID
//          is stalled, and presents one registered {pc, inst} per cycle to ID.
// Ports:   Clk          clock, all state on posedge
//          Rst          synchronous reset, active-high
//          stall        ctrl stall vector; [0] IF advance, [2] ID stage
//          flush        pipeline redirect, clears buffer and output
//          if_ce        fetch valid from pc_reg
//          if_pc        address of if_inst
//          if_inst      instruction fetched at if_pc
//          id_pc        registered pc for ID
//          id_inst      registered instruction for ID (zero = bubble)
//          id_valid     id_pc/id_inst hold a real fetched word
//          stallreq_if  buffer full, ctrl must hold IF
//          ovf          sticky: a push arrived while full and nothing popped
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic                   if_ce,
  input  logic [INST_ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0]      if_inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid,
  output logic                   stallreq_if,
  output logic                   ovf
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic   push, adv, empty, full, pop, bypass, wr_en, drop;
  fetch_t in_word, head_word;

  // stall bits owned by other stages are intentionally ignored here
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1]};

  assign in_word = '{pc: if_pc, inst: if_inst};

  assign push   = (if_ce == CHIP_ENABLE) && (stall[0] == NO_STOP) && !flush;
  assign adv    = (stall[2] == NO_STOP);
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign pop    = adv && !empty;
  // An empty buffer with ID advancing hands the word straight to the output.
  assign bypass = adv && empty && push;
  // A pop in the same cycle frees the slot the tail is about to reuse.
  assign wr_en  = push && !bypass && (!full || pop);
  assign drop   = push && full && !pop;

  assign stallreq_if = full;

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     ($bits(fetch_t))
  ) u_mem (
    .Clk     (Clk),
    .wr_en   (wr_en && (Rst != RST_ENABLE)),
    .wr_addr (wr_ptr),
    .wr_data (in_word),
    .rd_addr (rd_ptr),
    .rd_data (head_word)
  );

  always_ff @(posedge Clk) begin
    if (Rst == RST_ENABLE) begin
      id_pc    <= ZERO_WORD;
      id_inst  <= ZERO_WORD;
      id_valid <= 1'b0;
      ovf      <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (flush) begin
      id_pc    <= ZERO_WORD;
      id_inst  <= ZERO_WORD;
      id_valid <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (adv) begin
        if (pop) begin
          id_pc    <= head_word.pc;
          id_inst  <= head_word.inst;
          id_valid <= 1'b1;
        end else if (push) begin
          id_pc    <= if_pc;
          id_inst  <= if_inst;
          id_valid <= 1'b1;
        end else begin
          id_pc    <= ZERO_WORD;
          id_inst  <= ZERO_WORD;
          id_valid <= 1'b0;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
